// File: rtl/audio_frame_writer_pkg.sv
// Shared definitions for the audio frame writer and the sequencer it hands frames to.
// Holds the default geometry and the run-handshake state encoding.
package audio_frame_writer_pkg;

    localparam int DEF_CHAN_W  = 3;
    localparam int DEF_FRAME_W = 4;
    localparam int DEF_NCHAN   = 8;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    function automatic logic is_last_chan(input int unsigned chan, input int unsigned nchan);
        return chan == nchan - 1;
    endfunction

endpackage

// File: rtl/audio_frame_writer_frame_counter.sv
// Tracks the expected channel and the frame slot being written; flags frame completion.
// Completion is combinational so the top can act on it in the same cycle as the accept.
module frame_counter
    import audio_frame_writer_pkg::*;
#(
    parameter int CHAN_W  = DEF_CHAN_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int NCHAN   = DEF_NCHAN
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               i_accept,
    input  logic [CHAN_W-1:0]  i_chan,
    output logic [CHAN_W-1:0]  o_exp_chan,
    output logic [FRAME_W-1:0] o_wr_frame,
    output logic               o_complete
);

    logic [CHAN_W-1:0]  r_exp_chan;
    logic [FRAME_W-1:0] r_wr_frame;
    logic               w_last;

    assign w_last     = is_last_chan(int'(i_chan), NCHAN);
    assign o_complete = i_accept && w_last;
    assign o_exp_chan = r_exp_chan;
    assign o_wr_frame = r_wr_frame;

    // Expected channel follows the accepted one, so a glitch resynchronises immediately.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_exp_chan <= '0;
            r_wr_frame <= '0;
        end else if (i_accept) begin
            r_exp_chan <= w_last ? '0 : i_chan + CHAN_W'(1);
            if (w_last)
                r_wr_frame <= r_wr_frame + FRAME_W'(1);
        end
    end

endmodule

// File: rtl/audio_frame_writer.sv
// Writes channel-interleaved audio samples into a frame RAM and launches the sequencer
// once per completed frame, with sticky overrun / channel-sync error flags.
module audio_frame_writer
    import audio_frame_writer_pkg::*;
#(
    parameter int CHAN_W  = DEF_CHAN_W,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int NCHAN   = DEF_NCHAN
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [CHAN_W-1:0]         in_chan,
    input  logic signed [SAMPLE_W-1:0] in_data,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [CHAN_W+FRAME_W-1:0] wr_addr,
    output logic [SAMPLE_W-1:0]       wr_data,
    output logic [FRAME_W-1:0]        frame,
    output logic                      seq_run,
    input  logic                      seq_done,
    input  logic                      clr,
    output logic                      overrun,
    output logic                      sync_err
);

    logic                      w_accept;
    logic                      w_complete;
    logic                      w_take;
    logic [CHAN_W-1:0]         w_exp_chan;
    logic [FRAME_W-1:0]        w_wr_frame;
    seq_state_e                r_state;
    seq_state_e                w_state_nxt;

    logic                      r_wr_en;
    logic [CHAN_W+FRAME_W-1:0] r_wr_addr;
    logic [SAMPLE_W-1:0]       r_wr_data;
    logic [FRAME_W-1:0]        r_frame;
    logic                      r_pending;
    logic                      r_seq_run;
    logic                      r_overrun;
    logic                      r_sync_err;

    assign in_ready = ~rst;
    assign w_accept = in_valid & ~rst;

    frame_counter #(
        .CHAN_W (CHAN_W),
        .FRAME_W(FRAME_W),
        .NCHAN  (NCHAN)
    ) u_frame_counter (
        .ck        (ck),
        .rst       (rst),
        .i_accept  (w_accept),
        .i_chan    (in_chan),
        .o_exp_chan(w_exp_chan),
        .o_wr_frame(w_wr_frame),
        .o_complete(w_complete)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_state_nxt = ST_RUN;
                    w_take      = 1'b1;
                end
            end
            ST_RUN:   if (seq_done)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!seq_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_frame    <= '0;
            r_pending  <= 1'b0;
            r_seq_run  <= 1'b0;
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_wr_en   <= w_accept;
            r_seq_run <= (r_state == ST_RUN);
            if (w_accept) begin
                r_wr_addr <= {in_chan, w_wr_frame};
                r_wr_data <= in_data;
            end
            if (w_complete)
                r_frame <= w_wr_frame;
            // A fresh completion outranks the IDLE->RUN hand-off so the newest frame still runs.
            if (w_complete)  r_pending <= 1'b1;
            else if (w_take) r_pending <= 1'b0;
            if (w_complete && r_pending) r_overrun <= 1'b1;
            else if (clr)                r_overrun <= 1'b0;
            if (w_accept && (in_chan != w_exp_chan)) r_sync_err <= 1'b1;
            else if (clr)                             r_sync_err <= 1'b0;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign frame    = r_frame;
    assign seq_run  = r_seq_run;
    assign overrun  = r_overrun;
    assign sync_err = r_sync_err;

endmodule

// File: tb/tb_audio_frame_writer.sv
// Directed plus randomized bench for audio_frame_writer against a cycle-level reference model.
module tb_audio_frame_writer;

    localparam int NCHAN = 8;
    localparam int NFR   = 16;

    logic        ck = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_chan;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  frame;
    logic        seq_run;
    logic        seq_done;
    logic        clr;
    logic        overrun;
    logic        sync_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: state 0 = waiting, 1 = sequencer running, 2 = waiting for done to drop
    int m_exp, m_wf, m_frame, m_pend, m_st, m_run, m_ovr, m_serr, m_wen, m_addr, m_data, m_rdy;

    audio_frame_writer dut (
        .ck      (ck),
        .rst     (rst),
        .in_valid(in_valid),
        .in_chan (in_chan),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .frame   (frame),
        .seq_run (seq_run),
        .seq_done(seq_done),
        .clr     (clr),
        .overrun (overrun),
        .sync_err(sync_err)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("in_ready", {31'd0, in_ready}, m_rdy);
        chk("wr_en",    {31'd0, wr_en},    m_wen);
        chk("wr_addr",  {25'd0, wr_addr},  m_addr);
        chk("wr_data",  {16'd0, wr_data},  m_data);
        chk("frame",    {28'd0, frame},    m_frame);
        chk("seq_run",  {31'd0, seq_run},  m_run);
        chk("overrun",  {31'd0, overrun},  m_ovr);
        chk("sync_err", {31'd0, sync_err}, m_serr);
    endtask

    task automatic m_reset();
        m_exp = 0; m_wf = 0; m_frame = 0; m_pend = 0; m_st = 0; m_run = 0;
        m_ovr = 0; m_serr = 0; m_wen = 0; m_addr = 0; m_data = 0; m_rdy = 0;
    endtask

    task automatic cyc(input bit v, input int ch, input int d, input bit dn, input bit cl);
        bit comp;
        bit take;
        in_valid = v;
        in_chan  = 3'(ch);
        in_data  = 16'(d);
        seq_done = dn;
        clr      = cl;
        @(posedge ck);
        comp   = v && (ch == NCHAN - 1);
        take   = (m_st == 0) && (m_pend != 0);
        m_run  = (m_st == 1) ? 1 : 0;
        m_ovr  = (comp && m_pend != 0) ? 1 : (cl ? 0 : m_ovr);
        m_serr = (v && ch != m_exp) ? 1 : (cl ? 0 : m_serr);
        case (m_st)
            0: if (m_pend != 0) m_st = 1;
            1: if (dn) m_st = 2;
            default: if (!dn) m_st = 0;
        endcase
        m_pend = comp ? 1 : (take ? 0 : m_pend);
        m_wen  = v ? 1 : 0;
        if (v) begin
            m_addr = ch * NFR + m_wf;
            m_data = d & 'hFFFF;
            m_exp  = (ch + 1) % NCHAN;
        end
        if (comp) begin
            m_frame = m_wf;
            m_wf    = (m_wf + 1) % NFR;
        end
        #1;
        check_all();
    endtask

    task automatic send_frame(input bit dn);
        for (int c = 0; c < NCHAN; c++) cyc(1'b1, c, 'h0100 + c, dn, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; seq_done = 1'b0; clr = 1'b0;
        m_reset();
        repeat (2) @(posedge ck);
        #1;
        check_all();
        rst = 1'b0;
        m_rdy = 1;
        #1;
        check_all();

        // first frame, then watch seq_run rise two edges after the last channel
        send_frame(1'b0);
        chk("frame0_seqrun_e0", {31'd0, seq_run}, 0);
        cyc(1'b0, 7, 0, 1'b0, 1'b0);
        chk("frame0_seqrun_e1", {31'd0, seq_run}, 0);
        cyc(1'b0, 7, 0, 1'b0, 1'b0);
        chk("frame0_seqrun_e2", {31'd0, seq_run}, 1);

        // done pulse into drain, held high keeps drain, release returns to idle
        cyc(1'b0, 7, 0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 7, 0, 1'b1, 1'b0);
        chk("drain_held", {31'd0, seq_run}, 0);
        repeat (2) cyc(1'b0, 7, 0, 1'b0, 1'b0);

        // completions piling up while the sequencer never finishes
        repeat (3) send_frame(1'b0);
        repeat (2) cyc(1'b0, 7, 0, 1'b0, 1'b0);
        chk("overrun_set", {31'd0, overrun}, 1);
        repeat (2) cyc(1'b0, 7, 0, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 7, 0, 1'b0, 1'b0);
        chk("extra_run_frame", {28'd0, frame}, 3);
        repeat (2) cyc(1'b0, 7, 0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 7, 0, 1'b0, 1'b0);
        cyc(1'b0, 7, 0, 1'b0, 1'b1);
        chk("overrun_clr", {31'd0, overrun}, 0);

        // channel skip: 0,1,3 then 4 is expected (clr in the same cycle clears the flag)
        cyc(1'b1, 0, 'h0A00, 1'b0, 1'b0);
        cyc(1'b1, 1, 'h0A01, 1'b0, 1'b0);
        cyc(1'b1, 3, 'h0A03, 1'b0, 1'b0);
        chk("skip_sync_err", {31'd0, sync_err}, 1);
        cyc(1'b1, 4, 'h0A04, 1'b0, 1'b1);
        chk("resync_at_4", {31'd0, sync_err}, 0);
        for (int c = 5; c < NCHAN; c++) cyc(1'b1, c, 'h0A00 + c, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 7, 0, 1'b0, 1'b0);

        // asynchronous reset mid-run and mid-frame
        for (int c = 0; c <= 4; c++) cyc(1'b1, c, 'h0B00 + c, 1'b0, 1'b0);
        chk("pre_rst_run", {31'd0, seq_run}, 1);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        chk("async_rst_run", {31'd0, seq_run}, 0);
        @(negedge ck);
        rst = 1'b0;
        m_rdy = 1;
        send_frame(1'b0);
        chk("post_rst_frame", {28'd0, frame}, 0);
        chk("post_rst_serr", {31'd0, sync_err}, 0);
        chk("post_rst_ovr", {31'd0, overrun}, 0);
        repeat (3) cyc(1'b0, 7, 0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 7, 0, 1'b0, 1'b0);

        // seventeen more frames to wrap the frame index
        for (int f = 0; f < 17; f++)
            for (int c = 0; c < NCHAN; c++)
                cyc(1'b1, c, $urandom_range(0, 'hFFFF), 1'($urandom_range(0, 1)), 1'b0);

        // random traffic with occasional channel slips and clears
        for (int i = 0; i < 600; i++) begin
            automatic int ch = ($urandom_range(0, 15) == 0) ? $urandom_range(0, NCHAN - 1) : m_exp;
            cyc(1'($urandom_range(0, 3) != 0), ch, $urandom_range(0, 'hFFFF),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
